// File: rtl/dmem_wbuf_ctrl_if.sv
// Data-port bundle between the core, the write-buffered controller and the data-memory bus.
// The master modport is the controller's view; the slave modport is the core-plus-memory side.
interface dmem_wbuf_ctrl_if;
  logic [31:0] cpu_daddr;
  logic [31:0] cpu_dwdata;
  logic [3:0]  cpu_dwe;
  logic        cpu_dre;
  logic [31:0] cpu_drdata;
  logic        cpu_stall;
  logic        wb_empty;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  cpu_daddr, cpu_dwdata, cpu_dwe, cpu_dre,
    output cpu_drdata, cpu_stall, wb_empty,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output cpu_daddr, cpu_dwdata, cpu_dwe, cpu_dre,
    input  cpu_drdata, cpu_stall, wb_empty,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dmem_wbuf_ctrl.sv
// Data-side memory controller: posted write buffer drained to a req/gnt bus, loads stall until data returns.
// Optional store-to-load forwarding of fully covered words is enabled with `define DMEM_STORE_FWD_EN.
module dmem_wbuf_ctrl #(
  parameter int unsigned WB_DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  dmem_wbuf_ctrl_if.master bus
);

  localparam int unsigned PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wb_entry_t;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, RD_DONE} state_t;

  state_t           r_state, w_state_nxt;
  wb_entry_t        r_buf [WB_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_idx;
  logic [CNT_W-1:0] r_count;
  logic [29:0]      r_rd_addr;
  logic [31:0]      r_drdata;

  logic w_store, w_load, w_full, w_push, w_pop, w_hit, w_fwd, w_drain, w_unused;

  assign w_store  = |bus.cpu_dwe;
  assign w_load   = bus.cpu_dre && !w_store;
  assign w_full   = (r_count == CNT_W'(WB_DEPTH));
  assign w_push   = w_store && !w_full;
  assign w_unused = ^bus.cpu_daddr[1:0];
  assign bus.wb_empty = (r_count == '0);

`ifdef DMEM_STORE_FWD_EN
  logic [3:0]  w_fwd_mask;
  logic [31:0] w_fwd_data;
`endif

  // Match the load word against live entries, oldest first so younger lanes overwrite.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
`ifdef DMEM_STORE_FWD_EN
    w_fwd_mask = '0;
    w_fwd_data = '0;
`endif
    for (int unsigned k = 0; k < WB_DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (r_buf[w_idx].addr == bus.cpu_daddr[31:2])) begin
        w_hit = 1'b1;
`ifdef DMEM_STORE_FWD_EN
        for (int unsigned b = 0; b < 4; b++) begin
          if (r_buf[w_idx].be[b]) begin
            w_fwd_mask[b]       = 1'b1;
            w_fwd_data[8*b +: 8] = r_buf[w_idx].data[8*b +: 8];
          end
        end
`endif
      end
    end
  end

`ifdef DMEM_STORE_FWD_EN
  assign w_fwd          = (r_state == IDLE) && w_load && (w_fwd_mask == 4'hF);
  assign bus.cpu_drdata = w_fwd ? w_fwd_data : r_drdata;
`else
  assign w_fwd          = 1'b0;
  assign bus.cpu_drdata = r_drdata;
`endif

  // A pending miss load owns the bus; otherwise IDLE drains the head entry.
  assign w_drain = (r_state == IDLE) && (r_count != '0) && !(w_load && !w_hit);
  assign w_pop   = w_drain && bus.mem_gnt;

  always_comb begin
    w_state_nxt   = r_state;
    bus.cpu_stall = w_store && w_full;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_load && !w_fwd) begin
          bus.cpu_stall = 1'b1;
          if (!w_hit) w_state_nxt = RD_REQ;
        end
        if (w_drain) begin
          bus.mem_req   = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = {r_buf[r_rd_ptr].addr, 2'b00};
          bus.mem_be    = r_buf[r_rd_ptr].be;
          bus.mem_wdata = r_buf[r_rd_ptr].data;
        end
      end
      RD_REQ: begin
        bus.cpu_stall = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = {r_rd_addr, 2'b00};
        bus.mem_be    = 4'hF;
        if (bus.mem_gnt) w_state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        bus.cpu_stall = 1'b1;
        if (bus.mem_rvalid) w_state_nxt = RD_DONE;
      end
      RD_DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_addr <= '0;
      r_drdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if ((r_state == IDLE) && (w_state_nxt == RD_REQ)) r_rd_addr <= bus.cpu_daddr[31:2];
      if ((r_state == RD_WAIT) && bus.mem_rvalid) r_drdata <= bus.mem_rdata;
    end
  end

  // Entry storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wr_ptr] <= '{addr: bus.cpu_daddr[31:2], data: bus.cpu_dwdata, be: bus.cpu_dwe};
  end

endmodule

// File: tb/tb_dmem_wbuf_ctrl.sv
// Self-checking bench for dmem_wbuf_ctrl: vector table plus hand-written corner sequences,
// with bus writes and load data checked against scoreboard queues.
module tb_dmem_wbuf_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_wbuf_ctrl_if bus ();
  dmem_wbuf_ctrl #(.WB_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    bit          st;
    bit          ld;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          lat;
    logic [31:0] exp;
  } vec_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] mem_model [logic [31:0]];

  int          gnt_mode = 0;
  bit          gnt_rand = 1'b0;
  int          rd_lat = 1;
  int          rv_cnt = 0;
  logic [31:0] rv_data = '0;
  bit          rv_force = 1'b0;
  int          rd_grants = 0;

  assign bus.mem_gnt = bus.mem_req && ((gnt_mode == 1) || ((gnt_mode == 2) && gnt_rand));

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'h5A00_0000 | a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Memory responder: random grant pattern and read data after rd_lat cycles.
  always @(posedge clk) begin
    bit v;
    #2;
    gnt_rand = ($urandom_range(0, 1) == 1);
    v = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      v = (rv_cnt == 0);
    end
    bus.mem_rvalid = v || rv_force;
    bus.mem_rdata  = rv_force ? 32'h0000_DEAD : rv_data;
  end

  // Bus monitor: granted writes against the write scoreboard, reads against ordering rules.
  always @(negedge clk) begin
    wr_t         e;
    logic [31:0] w;
    bit          older;
    if (reset && bus.mem_req && bus.mem_gnt) begin
      if (bus.mem_we) begin
        if (exp_wr.size() == 0) flag_fail($sformatf("unexpected_write addr=%h", bus.mem_addr));
        else begin
          e = exp_wr.pop_front();
          check("wr_addr", bus.mem_addr, e.addr);
          check("wr_be", {28'h0, bus.mem_be}, {28'h0, e.be});
          check("wr_data", bus.mem_wdata, e.data);
        end
        w = mem_rd(bus.mem_addr);
        for (int b = 0; b < 4; b++) if (bus.mem_be[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
        mem_model[bus.mem_addr] = w;
      end else begin
        rd_grants++;
        check("rd_be", {28'h0, bus.mem_be}, 32'hF);
        check("rd_addr_lsb", {30'h0, bus.mem_addr[1:0]}, 32'h0);
        older = 1'b0;
        foreach (exp_wr[i]) if (exp_wr[i].addr == bus.mem_addr) older = 1'b1;
        check("read_after_older_writes", {31'h0, older}, 32'h0);
        rv_cnt  = rd_lat;
        rv_data = mem_rd(bus.mem_addr);
      end
    end
  end

  // Load completion monitor.
  always @(negedge clk) begin
    if (reset && bus.cpu_dre && (bus.cpu_dwe == 4'h0) && !bus.cpu_stall) begin
      if (exp_rd.size() == 0) flag_fail("unexpected_load_completion");
      else check("load_data", bus.cpu_drdata, exp_rd.pop_front());
    end
  end

  task automatic drive_idle();
    bus.cpu_daddr  = '0;
    bus.cpu_dwdata = '0;
    bus.cpu_dwe    = '0;
    bus.cpu_dre    = 1'b0;
  endtask

  task automatic wait_accept(input string name, output int stalls, output bit empty_at_done);
    bit done = 1'b0;
    stalls = 0;
    empty_at_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.cpu_stall) begin
        done = 1'b1;
        empty_at_done = bus.wb_empty;
        break;
      end
      stalls++;
    end
    if (!done) flag_fail({name, "_timeout"});
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input bit with_ld, output int stalls);
    bit e;
    exp_wr.push_back('{addr: a & ~32'h3, be: be, data: d});
    bus.cpu_daddr  = a;
    bus.cpu_dwdata = d;
    bus.cpu_dwe    = be;
    bus.cpu_dre    = with_ld;
    wait_accept("store", stalls, e);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp, output int stalls,
                         output bit empty_at_done);
    exp_rd.push_back(exp);
    bus.cpu_daddr = a;
    bus.cpu_dre   = 1'b1;
    wait_accept("load", stalls, empty_at_done);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.wb_empty) break;
    end
    check("drain_complete", {31'h0, bus.wb_empty}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[11];
    int   st;
    bit   e;
    int   g;

    vt[0]  = '{st: 1, ld: 0, addr: 32'h10,   data: 32'h0102_0304, be: 4'hF, lat: 1, exp: 32'h0};
    vt[1]  = '{st: 1, ld: 0, addr: 32'h14,   data: 32'hAAAA_AAAA, be: 4'h3, lat: 1, exp: 32'h0};
    vt[2]  = '{st: 1, ld: 0, addr: 32'h10,   data: 32'hFF00_0000, be: 4'h8, lat: 1, exp: 32'h0};
    vt[3]  = '{st: 0, ld: 1, addr: 32'h10,   data: 32'h0,         be: 4'h0, lat: 1, exp: 32'hFF02_0304};
    vt[4]  = '{st: 0, ld: 1, addr: 32'h14,   data: 32'h0,         be: 4'h0, lat: 3, exp: 32'h5A00_AAAA};
    vt[5]  = '{st: 0, ld: 1, addr: 32'h20,   data: 32'h0,         be: 4'h0, lat: 2, exp: 32'h5A00_0020};
    vt[6]  = '{st: 1, ld: 0, addr: 32'h23,   data: 32'h0000_BB00, be: 4'h2, lat: 1, exp: 32'h0};
    vt[7]  = '{st: 0, ld: 1, addr: 32'h20,   data: 32'h0,         be: 4'h0, lat: 1, exp: 32'h5A00_BB20};
    vt[8]  = '{st: 1, ld: 1, addr: 32'h30,   data: 32'h1212_1212, be: 4'hF, lat: 1, exp: 32'h0};
    vt[9]  = '{st: 0, ld: 1, addr: 32'h30,   data: 32'h0,         be: 4'h0, lat: 2, exp: 32'h1212_1212};
    vt[10] = '{st: 0, ld: 1, addr: 32'h1004, data: 32'h0,         be: 4'h0, lat: 1, exp: 32'h5A00_0001};

    drive_idle();
    mem_model[32'h100] = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'h0, bus.cpu_stall}, 32'h0);
    check("rst_wb_empty", {31'h0, bus.wb_empty}, 32'h1);
    check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_drdata", bus.cpu_drdata, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Fill the buffer with the bus blocked, then a fifth store must stall until grants flow.
    gnt_mode = 0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] bes [4] = '{4'hF, 4'h3, 4'hC, 4'h1};
      do_store(32'h1000 + 32'(4 * i), 32'hC000_0000 + 32'(i), bes[i], 1'b0, st);
      check($sformatf("store%0d_no_stall", i + 1), 32'(st), 32'h0);
    end
    exp_wr.push_back('{addr: 32'h1010, be: 4'hF, data: 32'hC000_0004});
    bus.cpu_daddr  = 32'h1010;
    bus.cpu_dwdata = 32'hC000_0004;
    bus.cpu_dwe    = 4'hF;
    @(negedge clk);
    check("store5_stall_when_full", {31'h0, bus.cpu_stall}, 32'h1);
    @(posedge clk);
    #1 gnt_mode = 1;
    wait_accept("store5", st, e);
    wait_empty();
    check("full_test_writes_done", 32'(exp_wr.size()), 32'h0);

    // Miss load on an empty buffer, immediate grant, data two cycles after grant.
    gnt_mode = 1;
    rd_lat = 2;
    do_load(32'h100, 32'h1234_5678, st, e);
    check("miss_load_stall_cycles", 32'(st), 32'd4);

    // Vector table with randomised grants.
    gnt_mode = 2;
    foreach (vt[i]) begin
      rd_lat = vt[i].lat;
      if (vt[i].st) do_store(vt[i].addr, vt[i].data, vt[i].be, vt[i].ld, st);
      else do_load(vt[i].addr, vt[i].exp, st, e);
    end
    wait_empty();

    // Hit load: buffered write must reach the bus before the read of the same word.
    gnt_mode = 0;
    do_store(32'h40, 32'hAABB_CCDD, 4'hF, 1'b0, st);
    gnt_mode = 2;
    rd_lat = 1;
    do_load(32'h40, 32'hAABB_CCDD, st, e);
    wait_empty();

    // Miss load bypasses a stalled buffered write.
    gnt_mode = 0;
    do_store(32'h200, 32'h0BAD_F00D, 4'hF, 1'b0, st);
    gnt_mode = 1;
    rd_lat = 1;
    do_load(32'h300, 32'h5A00_0300, st, e);
    check("read_before_drain_wb_not_empty", {31'h0, e}, 32'h0);
    check("bypass_load_stall_cycles", 32'(st), 32'd3);
    wait_empty();

    // Two overlapping stores to one word, then a load of it.
    gnt_mode = 0;
    do_store(32'h80, 32'h1122_3344, 4'hF, 1'b0, st);
    do_store(32'h80, 32'h0000_00EE, 4'h1, 1'b0, st);
    g = rd_grants;
`ifdef DMEM_STORE_FWD_EN
    do_load(32'h80, 32'h1122_33EE, st, e);
    check("fwd_load_no_stall", 32'(st), 32'h0);
    check("fwd_no_bus_read", 32'(rd_grants), 32'(g));
    gnt_mode = 1;
`else
    gnt_mode = 1;
    do_load(32'h80, 32'h1122_33EE, st, e);
    check("hit_load_stalled", {31'h0, (st > 0)}, 32'h1);
    check("hit_load_one_bus_read", 32'(rd_grants), 32'(g + 1));
`endif
    wait_empty();
    check("wr_scoreboard_empty", 32'(exp_wr.size()), 32'h0);
    check("rd_scoreboard_empty", 32'(exp_rd.size()), 32'h0);

    // Reset in the middle of RD_WAIT with a store still buffered; late rvalid must be ignored.
    gnt_mode = 0;
    do_store(32'h500, 32'h5555_5555, 4'hF, 1'b0, st);
    gnt_mode = 1;
    rd_lat = 20;
    bus.cpu_daddr = 32'h600;
    bus.cpu_dre   = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_in_rd_wait", {31'h0, bus.cpu_stall}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_idle();
    rv_cnt = 0;
    exp_wr.delete();
    exp_rd.delete();
    gnt_mode = 0;
    @(negedge clk);
    check("midrst_wb_empty", {31'h0, bus.wb_empty}, 32'h1);
    check("midrst_stall", {31'h0, bus.cpu_stall}, 32'h0);
    check("midrst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("midrst_drdata", bus.cpu_drdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    rv_force = 1'b1;
    @(negedge clk);
    check("late_rvalid_drdata", bus.cpu_drdata, 32'h0);
    check("late_rvalid_mem_req", {31'h0, bus.mem_req}, 32'h0);
    @(posedge clk);
    #1 rv_force = 1'b0;
    @(negedge clk);
    check("late_rvalid_no_rd_done", bus.cpu_drdata, 32'h0);
    check("late_rvalid_wb_empty", {31'h0, bus.wb_empty}, 32'h1);
    @(posedge clk);
    #1;
    gnt_mode = 1;
    rd_lat = 1;
    do_load(32'h600, 32'h5A00_0600, st, e);
    check("final_wr_scoreboard_empty", 32'(exp_wr.size()), 32'h0);
    check("final_rd_scoreboard_empty", 32'(exp_rd.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_wbuf_ctrl.md
Name: dmem_wbuf_ctrl

Overview:
Data-side memory controller sitting directly downstream of the cpu data port (daddr/dwdata/dwe/drdata).
- Accepts stores into a posted write buffer so the core does not wait on memory.
- Drains buffered stores to a req/gnt data-memory bus.
- Services loads over the same bus, stalling the core until read data returns.
- Guarantees every load observes all older stores to the same word.

Parameters:
WB_DEPTH, 4, write-buffer entries; power of 2, minimum 2.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low (0 = in reset).
cpu_daddr  in  32  load/store byte address; [1:0] ignored, word granularity.
cpu_dwdata  in  32  store data, byte-lane aligned.
cpu_dwe  in  4  store byte enables; non-zero = store.
cpu_dre  in  1  load request.
cpu_drdata  out  32  load data; valid in the cycle a load completes.
cpu_stall  out  1  core must hold PC and all inputs while 1.
wb_empty  out  1  write buffer holds no entries.
mem_req  out  1  bus request.
mem_we  out  1  1 = write, 0 = read.
mem_addr  out  32  word address, [1:0] always 0.
mem_be  out  4  write byte enables; 4'b1111 on reads.
mem_wdata  out  32  write data.
mem_gnt  in  1  request accepted this cycle.
mem_rvalid  in  1  read data valid; arrives 1 or more cycles after gnt.
mem_rdata  in  32  read data.

Behaviour:
- Reset (async, low):
  - Buffer empty; pointers and count 0.
  - FSM to IDLE.
  - mem_req, mem_we, cpu_stall, cpu_drdata, mem_addr, mem_be, mem_wdata all 0.
  - wb_empty 1.
- Store (cpu_dwe != 0):
  - Count < WB_DEPTH: entry {addr[31:2], wdata, be} enqueued at the clock edge; cpu_stall 0.
  - Count == WB_DEPTH: cpu_stall 1 until count < WB_DEPTH; no enqueue while full, even when a pop occurs in the same cycle.
- Store and load together: if cpu_dwe != 0 and cpu_dre = 1, the store wins and cpu_dre is ignored.
- Pointers wrap modulo WB_DEPTH.
- Same-cycle enqueue and pop leave count unchanged.
- FSM states:
  - IDLE
  - RD_REQ: mem_req=1, mem_we=0, address held until gnt.
  - RD_WAIT: wait for mem_rvalid.
  - RD_DONE: cpu_drdata = captured rdata, cpu_stall 0 for exactly 1 cycle, then IDLE.
- Load in IDLE, no buffer entry matching the word address:
  - Go to RD_REQ in the next cycle.
  - cpu_stall 1 from the load cycle through RD_WAIT.
  - The read has priority over draining.
- Load in IDLE, at least one matching buffer entry (hit):
  - cpu_stall 1.
  - Buffer drains until no matching entry remains, then go to RD_REQ.
- Minimum load latency: load cycle → RD_REQ (gnt same cycle) → RD_WAIT (rvalid same cycle) → RD_DONE = 3 stall cycles. Data is delivered in RD_DONE.
- Drain:
  - In IDLE with the buffer non-empty and no pending non-hit load, drive the head entry: mem_req=1, mem_we=1, mem_addr = {addr,2'b00}, mem_be, mem_wdata.
  - Pop on mem_gnt.
  - The request must stay stable until gnt.
  - mem_req drops the cycle after the final pop if nothing else is pending.
- When mem_req = 0, mem_addr, mem_be and mem_wdata are don't-care.
- mem_rvalid outside RD_WAIT is ignored.
- Reset asserted mid-transaction:
  - The outstanding bus transaction is abandoned.
  - Buffered stores are discarded.
  - Late rvalid is ignored.
- cpu_drdata holds its last value outside RD_DONE.
- wb_empty is combinational, (count == 0).

Optional Feature:
DMEM_STORE_FWD_EN.
- Defined: on a load hit, byte lanes are merged from all matching entries, youngest wins per lane.
  - All 4 lanes covered: cpu_drdata = merged word in the same cycle, cpu_stall 0, no bus read.
  - Otherwise: the undefined-macro behaviour applies.
- Undefined: every hit drains to the miss state, then reads memory.

Test Plan:
- Reset low mid-RD_WAIT, then rvalid with 32'hDEAD → FSM IDLE, no RD_DONE, cpu_drdata 0, wb_empty 1.
- 5 back-to-back stores, gnt tied 0, WB_DEPTH=4 → stores 1-4 no stall; 5th stall=1; raise gnt → 4 writes appear in order with correct addresses/be; 5th then accepted.
- Load 0x100 with empty buffer, gnt immediate, rvalid 2 cycles after gnt with 32'h12345678 → stall 4 cycles, cpu_drdata 32'h12345678 in RD_DONE, mem_be 4'hF.
- Store 32'hAABBCCDD be=4'b1111 to 0x40, then load 0x40, gnt delayed → write to 0x40 granted before any read to 0x40; load returns memory value.
- DMEM_STORE_FWD_EN: store 32'h11223344 be=4'hF then 32'h000000EE be=4'h1 to 0x80; load 0x80 → cpu_drdata 32'h112233EE same cycle, stall 0, no mem read.
- Store to 0x200 buffered with gnt 0, load 0x300 → read issued before the drain, buffer count stays 1 until read completes.
